// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: bundles the two-requester request/response handshakes
// and the operand/result wires to the shared combinational ALU.
//
// Handshake rule (both request and response channels): a transfer happens
// on a rising clock edge where valid and ready for the same requester bit
// are both high. Valid may drop without a transfer (a withdrawn request is
// never executed). The arbiter's ready may depend combinationally on valid.
//
// slave  : the arbiter's view (requests in, responses and ALU operands out).
// master : the requesters' and ALU's view.
interface alu_share_arb_if #(
  parameter int XLEN = 32,
  parameter int CW   = 5
);

  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0][XLEN-1:0]    req_a;
  logic [1:0][XLEN-1:0]    req_b;
  logic [1:0][CW-1:0]      req_ctrl;

  logic [1:0]              rsp_valid;
  logic [1:0]              rsp_ready;
  logic [XLEN-1:0]         rsp_result;
  logic [3:0]              rsp_flags;
  logic                    rsp_err;

  logic [XLEN-1:0]         alu_a;
  logic [XLEN-1:0]         alu_b;
  logic [CW-1:0]           alu_ctrl;
  logic [XLEN-1:0]         alu_result;
  logic [3:0]              alu_flags;

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, rsp_ready, alu_result, alu_flags,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err,
           alu_a, alu_b, alu_ctrl
  );

  modport master (
    output req_valid, req_a, req_b, req_ctrl, rsp_ready, alu_result, alu_flags,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err,
           alu_a, alu_b, alu_ctrl
  );

endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter/sequencer sharing one combinational
// RV32I ALU between two requesters.
//
// Flow: IDLE --accept--> EXEC (ALU driven from operand registers for one
// cycle, result captured) --> RESP (result held until the owner's
// rsp_ready). A new request may be accepted in the same cycle the response
// completes, giving one operation every two cycles when streaming.
//
// Optional feature macro: ALU_ARB_CTRL_CHECK_EN
//   defined   : control codes above 9 are flagged at accept; the ALU is
//               driven with code 0, the response carries result 0, flags 0
//               and rsp_err = 1.
//   undefined : codes pass through unchanged and rsp_err is tied to 0.
//
// dbg_state exposes the FSM state (IDLE = 0, EXEC = 1, RESP = 2).
module alu_share_arb #(
  parameter int XLEN = 32,
  parameter int CW   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_share_arb_if.slave        bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [CW-1:0]   op_ctrl;
  logic            op_id;
  logic            last_grant;
  logic [XLEN-1:0] res;
  logic [3:0]      flg;

  logic            any_req;
  logic            win_id;
  logic            rsp_fire;
  logic            accept_open;
  logic            accept;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic [CW-1:0]   sel_ctrl;

`ifdef ALU_ARB_CTRL_CHECK_EN
  // Highest legal control code (sltu); anything above is rejected.
  localparam logic [CW-1:0] CTRL_MAX = CW'(9);

  logic            err;
  logic            ctrl_bad;

  assign ctrl_bad = (sel_ctrl > CTRL_MAX);
`endif

  // Round-robin pick: a lone requester wins; on a tie the one that did not
  // win last time gets the grant.
  always_comb begin
    any_req = |bus.req_valid;
    win_id  = 1'b0;
    case (bus.req_valid)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = ~last_grant;
      default: win_id = 1'b0;
    endcase
  end

  assign sel_a    = bus.req_a[win_id];
  assign sel_b    = bus.req_b[win_id];
  assign sel_ctrl = bus.req_ctrl[win_id];

  // The response completes only on the owner's ready; the other bit is
  // ignored. The accept window opens in IDLE or when the response retires.
  assign rsp_fire    = (state == RESP) & bus.rsp_ready[op_id];
  assign accept_open = rst_n & ((state == IDLE) | rsp_fire);

  // Grant decode: at most one ready bit, only toward the current winner.
  always_comb begin
    bus.req_ready = 2'b00;
    if (accept_open && any_req) begin
      bus.req_ready[win_id] = 1'b1;
    end
  end

  assign accept = |(bus.req_valid & bus.req_ready);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: EXEC is always a single cycle; RESP waits for the
  // owner's ready and may chain straight into the next operation.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_fire) state_nxt = accept ? EXEC : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch at accept, result/flag capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= '0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
      res        <= '0;
      flg        <= '0;
`ifdef ALU_ARB_CTRL_CHECK_EN
      err        <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_a       <= sel_a;
        op_b       <= sel_b;
        op_id      <= win_id;
        last_grant <= win_id;
`ifdef ALU_ARB_CTRL_CHECK_EN
        op_ctrl    <= ctrl_bad ? '0 : sel_ctrl;
        err        <= ctrl_bad;
`else
        op_ctrl    <= sel_ctrl;
`endif
      end
      if (state == EXEC) begin
`ifdef ALU_ARB_CTRL_CHECK_EN
        res <= err ? '0 : bus.alu_result;
        flg <= err ? '0 : bus.alu_flags;
`else
        res <= bus.alu_result;
        flg <= bus.alu_flags;
`endif
      end
    end
  end

  // The shared ALU always sees the operand registers, so its inputs only
  // change on an accept edge.
  assign bus.alu_a    = op_a;
  assign bus.alu_b    = op_b;
  assign bus.alu_ctrl = op_ctrl;

  // Response routing: one valid bit toward the owner; data on shared bus.
  assign bus.rsp_valid  = (state == RESP) ? (op_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result = res;
  assign bus.rsp_flags  = flg;
`ifdef ALU_ARB_CTRL_CHECK_EN
  assign bus.rsp_err    = err;
`else
  assign bus.rsp_err    = 1'b0;
`endif

  assign dbg_state = state;

  // Structural invariants of the sequencer.
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));

  a_exec_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    (state == EXEC) |=> (state == RESP));

  a_exec_no_grant: assert property (@(posedge clk) disable iff (!rst_n)
    (state == EXEC) |-> (bus.req_ready == 2'b00));

  a_resp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RESP && !rsp_fire) |=>
      (state == RESP && $stable(bus.rsp_result) && $stable(bus.rsp_flags)
       && $stable(bus.rsp_valid) && $stable(bus.rsp_err)));

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port round-robin arbiter and sequencer that shares one combinational RV32I ALU between two requesters, e.g. the EX-stage integer path and the branch/address-compare unit. Each requester issues a valid/ready operand request (a, b, 5-bit ALU control code). The block latches the winning request, drives the shared ALU from registers for one cycle, captures result and flags, and returns them to the originating requester through a valid/ready response port.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `CW`, 5: ALU control code width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i is requester i.
- `req_ready`  out  2  per-requester request accept.
- `req_a`  in  2×XLEN  operand A per requester.
- `req_b`  in  2×XLEN  operand B per requester.
- `req_ctrl`  in  2×CW  ALU control code per requester.
- `rsp_valid`  out  2  per-requester response valid.
- `rsp_ready`  in  2  per-requester response accept.
- `rsp_result`  out  XLEN  shared result bus; it is valid for the requester whose `rsp_valid` bit is set.
- `rsp_flags`  out  4  ALU flags {N,Z,C,V}.
- `rsp_err`  out  1  illegal control code (see Configuration).
- `alu_a`  out  XLEN  operand A driven to the shared ALU.
- `alu_b`  out  XLEN  operand B driven to the shared ALU.
- `alu_ctrl`  out  CW  control code driven to the shared ALU.
- `alu_result`  in  XLEN  combinational ALU result.
- `alu_flags`  in  4  combinational ALU flags {aN,aZ,aC,aV}.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Registers: `op_a`, `op_b`, `op_ctrl`, `op_id` (1 bit), `last_grant` (1 bit), `res`, `flg`, `err`.
- `alu_a`, `alu_b` and `alu_ctrl` are driven from `op_a`, `op_b` and `op_ctrl` at all times.
- Arbitration:
  - If exactly one `req_valid` bit is set, that requester wins.
  - If both are set, the requester not equal to `last_grant` wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `last_grant` updates to the winner on every accepted request.
- Accept window: IDLE, or RESP in the same cycle that the pending response handshake completes.
- `req_ready[i]` is set only when the accept window is open and i is the winner. At most one `req_ready` bit is high. `req_ready` may depend combinationally on `req_valid` and `rsp_ready`.
- Accept edge (`req_valid[i] & req_ready[i]`):
  - Latch operands, control code and `op_id = i`.
  - Go to EXEC.
- EXEC: on the next edge, capture `alu_result` into `res` and `alu_flags` into `flg`, then go to RESP. EXEC always lasts exactly one cycle.
- RESP:
  - `rsp_valid[op_id] = 1`; the other bit is 0.
  - `rsp_result`, `rsp_flags` and `rsp_err` are held stable until the handshake completes.
  - On `rsp_ready[op_id]`: go to EXEC if a new request is accepted in the same cycle, otherwise go to IDLE.
- `rsp_ready` for the non-owning requester is ignored.
- A requester that deasserts `req_valid` without a handshake is legal. A request withdrawn before its handshake is not executed.
- Reset mid-operation: the in-flight operation is discarded and no response is issued.
- Reset values:
  - `req_ready = 0`, `rsp_valid = 0`.
  - `rsp_result = 0`, `rsp_flags = 0`, `rsp_err = 0`.
  - `alu_a = 0`, `alu_b = 0`, `alu_ctrl = 0` (add).

## Timing
- Request accepted at edge E0.
- ALU operands are stable from E0 through E1.
- Result is registered at E1; `rsp_valid` is high after E1.
- Earliest response handshake is at E2.
- Minimum latency from request handshake to `rsp_valid` is 2 cycles.
- Sustained throughput, with `rsp_ready` held high and a new request waiting: one operation per 2 cycles.
- Backpressure: `rsp_ready = 0` holds the block in RESP indefinitely. During that time `req_ready` stays 0 for both requesters.
- Grant fairness: with both requesters continuously valid, grants alternate 0, 1, 0, 1, …

## Configuration
- Macro: `ALU_ARB_CTRL_CHECK_EN`.
- Defined:
  - Control codes above 5'b01001 (legal set 0–9: add, sub, and, or, xor, slt, sll, srl, sra, sltu) are flagged at accept.
  - For a flagged code, `op_ctrl` is forced to 0 and `err` is set.
  - At E1 the block captures `res = 0` and `flg = 0`. The response has `rsp_err = 1`.
  - Latency is unchanged.
- Undefined: `rsp_err` is tied to 0, codes are forwarded unchanged, and the result is whatever the ALU returns.

## Test plan
- Single request, requester 0: a = 5, b = 3, ctrl = 00001 (sub). Required: `alu_a`/`alu_b` = 5/3 during EXEC; `rsp_valid = 2'b01` two cycles after accept; `rsp_result = 2`; `rsp_flags = {0,0,1,0}`.
- Both requesters continuously valid for 4 operations, `rsp_ready = 2'b11`. Required: grant order 0, 1, 0, 1; responses routed only to the matching `rsp_valid` bit; one response every 2 cycles.
- Backpressure: requester 1 result 0xFFFFFFFF with `rsp_ready[1] = 0` for 5 cycles, requester 0 valid throughout. Required: `req_ready = 0` and `rsp_result` held stable; requester 0 is accepted in the cycle `rsp_ready[1]` rises.
- Wrong-owner ready: response pending for requester 0, `rsp_ready = 2'b10`. Required: block stays in RESP and `rsp_valid` stays 2'b01.
- Reset during EXEC: `rst_n` low mid-cycle. Required: all outputs go to reset values immediately; no response is issued after release; the next tie grants requester 0.
- With `ALU_ARB_CTRL_CHECK_EN` defined, ctrl = 5'b11111. Required: `alu_ctrl = 0` in EXEC; response has `rsp_err = 1`, `rsp_result = 0`, `rsp_flags = 0`.
